// File: rtl/result_reader_if.sv
// FIFO read port plus decoded-word stream of result_reader, grouped for port hookup.
// master is the reader block; slave is the FIFO owner together with the word consumer.
interface result_reader_if #(
  parameter int CNT_W = 10
) ();
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_data_count;
  logic [31:0]      fifo_rd_data;
  logic             fifo_rden;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data_count,
    input  fifo_rd_data,
    input  m_ready,
    output fifo_rden,
    output m_data,
    output m_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data_count,
    output fifo_rd_data,
    output m_ready,
    input  fifo_rden,
    input  m_data,
    input  m_valid
  );
endinterface

// File: rtl/result_reader.sv
// Pops words from a standard-mode FIFO, decodes them by reg0 mode and presents them
// on a valid/ready stream; also counts deliveries and raises a sticky level interrupt.
module result_reader #(
  parameter int THRESH = 16,
  parameter int CNT_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [31:0]     reg0,
  input  logic            intr_clr,
  output logic            intr,
  output logic [15:0]     word_cnt,
  result_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_fetch_ok;
  logic        w_handshake;
  logic        w_fifo_rden;
  logic        w_m_valid;
  logic [31:0] r_m_data;
  logic        r_intr;
  logic [15:0] r_word_cnt;

  // mode 0 inverts, mode 1 subtracts one (0 wraps to all ones), anything else passes
  function automatic logic [31:0] decode(input logic [31:0] d, input logic [31:0] mode);
    logic [31:0] res;
    if (mode == 32'd0)      res = ~d;
    else if (mode == 32'd1) res = d - 32'd1;
    else                    res = d;
    return res;
  endfunction

  assign w_fetch_ok  = enable && !bus.fifo_empty;
  assign w_handshake = w_m_valid && bus.m_ready;

  // NOTE: non-blocking assignments make every register see pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_fifo_rden  = 1'b0;
    w_m_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fetch_ok) w_next_state = FETCH;
      end
      FETCH: begin
        w_fifo_rden  = 1'b1;
        w_next_state = CAPTURE;
      end
      CAPTURE: begin
        w_next_state = PRESENT;
      end
      PRESENT: begin
        w_m_valid = 1'b1;
        if (bus.m_ready) w_next_state = w_fetch_ok ? FETCH : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FIFO dout is valid during CAPTURE; reg0 is taken here so later mode changes
  // only affect later words, and the register holds through PRESENT back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_m_data <= 32'd0;
    else if (r_state == CAPTURE) r_m_data <= decode(bus.fifo_rd_data, reg0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_word_cnt <= 16'd0;
    else if (w_handshake) r_word_cnt <= r_word_cnt + 16'd1;
  end

  // Set has priority over clear so a level still above threshold cannot be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_intr <= 1'b0;
    else if (bus.fifo_data_count >= CNT_W'(THRESH)) r_intr <= 1'b1;
    else if (intr_clr)                                r_intr <= 1'b0;
  end

  assign bus.fifo_rden = w_fifo_rden;
  assign bus.m_valid   = w_m_valid;
  assign bus.m_data    = r_m_data;
  assign intr          = r_intr;
  assign word_cnt      = r_word_cnt;

endmodule

// File: tb/tb_result_reader.sv
// Randomized and directed bench for result_reader against a queue-based FIFO and
// delivery model; every cycle is scored for data, hold, interrupt and word count.
module tb_result_reader;
  localparam int THRESH = 16;
  localparam int CNT_W  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        intr_clr;
  logic        intr;
  logic [31:0] reg0;
  logic [15:0] word_cnt;

  result_reader_if #(.CNT_W(CNT_W)) bus ();

  result_reader #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .reg0     (reg0),
    .intr_clr (intr_clr),
    .intr     (intr),
    .word_cnt (word_cnt),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] seen_q[$];
  int          rden_cyc[$];
  logic [31:0] pend_word;
  logic        pend_valid;
  logic [15:0] exp_wcnt;
  logic        exp_intr;
  bit          cnt_force;
  int          cyc;
  int          rden_pulses;
  int          hs_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Decode rule written as plain arithmetic modulo 2^32.
  function automatic logic [31:0] model_decode(input logic [31:0] d, input logic [31:0] mode);
    if (mode == 32'd0) return 32'hFFFF_FFFF - d;
    if (mode == 32'd1) return d + 32'hFFFF_FFFF;
    return d;
  endfunction

  function automatic void sync_flags();
    bus.fifo_empty = (fifo_q.size() == 0);
    if (!cnt_force) bus.fifo_data_count = CNT_W'(fifo_q.size());
  endfunction

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    sync_flags();
  endtask

  function automatic void model_clear();
    fifo_q.delete();
    exp_q.delete();
    seen_q.delete();
    rden_cyc.delete();
    pend_valid  = 1'b0;
    exp_wcnt    = 16'd0;
    exp_intr    = 1'b0;
    cnt_force   = 1'b0;
    rden_pulses = 0;
    hs_total    = 0;
    sync_flags();
  endfunction

  // One clock: score pre-edge handshake, advance the FIFO model, check post-edge state.
  task automatic tick();
    logic        rden_b, valid_b, ready_b, empty_b, clr_b;
    logic [31:0] data_b;
    int          cnt_b;
    rden_b  = bus.fifo_rden;
    valid_b = bus.m_valid;
    ready_b = bus.m_ready;
    empty_b = bus.fifo_empty;
    clr_b   = intr_clr;
    data_b  = bus.m_data;
    cnt_b   = int'(bus.fifo_data_count);
    if (pend_valid) begin
      exp_q.push_back(model_decode(pend_word, reg0));
      pend_valid = 1'b0;
    end
    if (valid_b && ready_b) begin
      hs_total++;
      exp_wcnt = exp_wcnt + 16'd1;
      seen_q.push_back(data_b);
      if (exp_q.size() == 0) check("hs_without_word", 32'(valid_b), 32'd0);
      else                   check("m_data", data_b, exp_q.pop_front());
    end
    if (cnt_b >= THRESH) exp_intr = 1'b1;
    else if (clr_b)      exp_intr = 1'b0;

    @(posedge clk);
    #1;
    cyc++;
    if (rden_b) begin
      rden_pulses++;
      check("rden_one_cycle", 32'(bus.fifo_rden), 32'd0);
      if (fifo_q.size() == 0) begin
        check("pop_when_empty", 32'(rden_b), 32'd0);
        bus.fifo_rd_data = 32'hDEAD_BEEF;
      end else begin
        pend_word        = fifo_q.pop_front();
        pend_valid       = 1'b1;
        bus.fifo_rd_data = pend_word;
      end
    end
    if (bus.fifo_rden) rden_cyc.push_back(cyc);
    if (empty_b) check("rden_after_empty", 32'(bus.fifo_rden), 32'd0);
    if (valid_b && !ready_b) begin
      check("hold_valid", 32'(bus.m_valid), 32'd1);
      check("hold_data", bus.m_data, data_b);
    end
    check("intr", 32'(intr), 32'(exp_intr));
    check("word_cnt", 32'(word_cnt), 32'(exp_wcnt));
    sync_flags();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rden", 32'(bus.fifo_rden), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_m_data", bus.m_data, 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int n = 0;
    while (!bus.m_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.m_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    enable     = 1'b1;
    bus.m_ready = 1'b1;
    intr_clr   = 1'b0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || pend_valid || bus.m_valid) && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(fifo_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] w [3];
    logic [31:0] hold;
    int          pulses0;
    int          n;

    rst = 1'b1; enable = 1'b0; intr_clr = 1'b0; reg0 = 32'd0;
    bus.m_ready = 1'b0; bus.fifo_rd_data = 32'd0; cyc = 0;
    model_clear();
    do_reset();

    // Single word, invert mode: latency and value.
    reg0 = 32'd0; enable = 1'b1; bus.m_ready = 1'b1;
    push(32'hFFFF_FFFE);
    tick();
    check("lat_rden_k1", 32'(bus.fifo_rden), 32'd1);
    check("lat_valid_k1", 32'(bus.m_valid), 32'd0);
    tick();
    check("lat_rden_k2", 32'(bus.fifo_rden), 32'd0);
    check("lat_valid_k2", 32'(bus.m_valid), 32'd0);
    tick();
    check("lat_valid_k3", 32'(bus.m_valid), 32'd1);
    check("inv_data", bus.m_data, 32'h0000_0001);
    tick();
    check("valid_one_cycle", 32'(bus.m_valid), 32'd0);
    check("word_cnt_one", 32'(word_cnt), 32'd1);
    check("one_rden", 32'(rden_pulses), 32'd1);

    // Subtract mode with wrap, back-to-back words 3 cycles apart.
    reg0 = 32'd1; seen_q.delete(); rden_cyc.delete();
    push(32'h0000_0000);
    push(32'h0000_0010);
    repeat (12) tick();
    check("sub_count", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      check("sub_wrap", seen_q[0], 32'hFFFF_FFFF);
      check("sub_16", seen_q[1], 32'h0000_000F);
    end
    check("rden_pair", 32'(rden_cyc.size()), 32'd2);
    if (rden_cyc.size() == 2) check("rden_spacing", 32'(rden_cyc[1] - rden_cyc[0]), 32'd3);

    // Back-pressure, plus a mode change while a word is held.
    reg0 = 32'd2; bus.m_ready = 1'b0; seen_q.delete();
    foreach (w[i]) begin
      w[i] = $urandom;
      push(w[i]);
    end
    wait_valid(6, "bp_valid");
    reg0    = 32'd0;
    hold    = bus.m_data;
    pulses0 = rden_pulses;
    repeat (10) tick();
    check("bp_still_valid", 32'(bus.m_valid), 32'd1);
    check("bp_data_held", bus.m_data, hold);
    check("bp_no_rden", 32'(rden_pulses - pulses0), 32'd0);
    bus.m_ready = 1'b1;
    tick();
    check("bp_next_rden", 32'(bus.fifo_rden), 32'd1);
    drain("bp_drain");
    check("bp_seen", 32'(seen_q.size()), 32'd3);
    if (seen_q.size() == 3) begin
      check("mode_old_word", seen_q[0], w[0]);
      check("mode_new_w1", seen_q[1], ~w[1]);
      check("mode_new_w2", seen_q[2], ~w[2]);
    end

    // Dropping enable after a fetch lets that word finish but starts no more.
    reg0 = 32'd7; seen_q.delete(); rden_pulses = 0;
    push($urandom);
    push($urandom);
    tick();
    enable = 1'b0;
    repeat (8) tick();
    check("en_one_word", 32'(seen_q.size()), 32'd1);
    check("en_one_rden", 32'(rden_pulses), 32'd1);
    drain("en_drain");

    // Sticky interrupt: set on threshold, set beats clear, clear only below threshold.
    cnt_force = 1'b1;
    bus.fifo_data_count = CNT_W'(15);
    tick();
    check("intr_15", 32'(intr), 32'd0);
    bus.fifo_data_count = CNT_W'(16);
    tick();
    check("intr_16", 32'(intr), 32'd1);
    intr_clr = 1'b1;
    tick();
    check("intr_set_wins", 32'(intr), 32'd1);
    intr_clr = 1'b0;
    bus.fifo_data_count = CNT_W'(3);
    tick();
    check("intr_sticky", 32'(intr), 32'd1);
    intr_clr = 1'b1;
    tick();
    check("intr_cleared", 32'(intr), 32'd0);
    intr_clr = 1'b0;

    // Asynchronous reset while presenting a word with intr set.
    bus.fifo_data_count = CNT_W'(20);
    bus.m_ready = 1'b0; enable = 1'b1;
    push($urandom);
    wait_valid(6, "ar_valid");
    check("ar_intr_before", 32'(intr), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_valid_low", 32'(bus.m_valid), 32'd0);
    check("ar_rden_low", 32'(bus.fifo_rden), 32'd0);
    check("ar_intr_low", 32'(intr), 32'd0);
    check("ar_data_zero", bus.m_data, 32'd0);
    check("ar_wcnt_zero", 32'(word_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.m_ready = 1'b1;
    push(32'h1234_5678);
    wait_valid(8, "ar_restart_valid");
    drain("ar_drain");
    check("ar_restart_word", 32'(seen_q.size()), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 4) < 3);
      intr_clr    = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       reg0 = 32'd0;
        1:       reg0 = 32'd1;
        default: reg0 = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 24) push($urandom);
      tick();
    end
    drain("rand_drain");

    // Word counter wrap through a full 16-bit count of handshakes.
    do_reset();
    reg0 = 32'd2; enable = 1'b1; bus.m_ready = 1'b1;
    n = 0;
    while (hs_total < 65535 && n < 200_000) begin
      if (fifo_q.size() < 2) push($urandom);
      tick();
      n++;
    end
    check("wrap_pre", 32'(word_cnt), 32'h0000_FFFF);
    while (hs_total < 65536 && n < 200_010) begin
      if (fifo_q.size() < 2) push($urandom);
      tick();
      n++;
    end
    check("wrap_zero", 32'(word_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
